irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 6, number of interrupt sources (2..8).
REQ-002 Parameter IDW, default 3, width of source id; SHALL satisfy 2**IDW >= NSRC.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 src  input  NSRC  raw interrupt lines; bit0 = Timer0, bit1 = Timer1, bit2 = external interrupt, rest reserved.
REQ-006 addr  input  2  word offset within controller window: 0 MASK, 1 PEND, 2 ISR, 3 EOI.
REQ-007 we  input  1  register write strobe from bridge.
REQ-008 wdata  input  32  register write data.
REQ-009 rdata  output  32  combinational register read data; zero-extended; 0 for EOI offset.
REQ-010 irq_req  output  1  interrupt request to CPU, registered.
REQ-011 irq_id  output  IDW  id of requested source, valid while irq_req=1, registered.
REQ-012 irq_ack  input  1  one-cycle CPU acceptance pulse.
REQ-013 eoi  input  1  one-cycle end-of-interrupt pulse (CPU eret).

Function
REQ-014 Pending bit p[i] SHALL set in the cycle after src[i] is sampled active (level mode) or rising (edge mode, see Configuration).
REQ-015 Write to PEND SHALL clear p[i] for each wdata[i]=1 (write-1-to-clear); same-cycle set event wins over clear.
REQ-016 MASK[i]=1 enables source i; write to MASK loads wdata[NSRC-1:0]; masking SHALL NOT clear pending bits.
REQ-017 Eligible set = p & MASK & ~ISR; grant SHALL go to lowest-index eligible source (fixed priority).
REQ-018 FSM states IDLE, REQ, SERVICE; encoded in 2 bits.
REQ-019 IDLE -> REQ when eligible set non-empty; irq_req=1 and irq_id latched in same edge; latency src edge -> irq_req = 2 cycles.
REQ-020 In REQ, irq_id SHALL update if a higher-priority source becomes eligible before irq_ack; irq_req stays 1.
REQ-021 REQ -> IDLE without ack if eligible set becomes empty (pending cleared or masked); irq_req drops next edge.
REQ-022 REQ + irq_ack -> SERVICE: p[irq_id] cleared, ISR[irq_id] set, irq_req=0 on same edge.
REQ-023 SERVICE -> IDLE on eoi pulse or write to EOI offset; ISR cleared entirely; both in same cycle count once.
REQ-024 irq_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-025 ISR register read-only; writes to ISR offset ignored.
REQ-026 No nesting: new requests held pending while in SERVICE.

Reset
REQ-027 On reset: state IDLE, p=0, MASK=0, ISR=0, irq_req=0, irq_id=0, edge-detect history=0.
REQ-028 Reset mid-REQ or mid-SERVICE SHALL abort without any further irq_req pulse; reset dominates we, irq_ack, eoi.

Configuration
REQ-029 Macro IRQ_CTRL_EDGE_EN: defined -> pending set only on 0->1 transition of src (registered history), holding src high sets p once; undefined -> level mode, p re-sets every cycle src is high, history register absent.

Structure
REQ-030 Shared package irq_pkg holds state enum (IDLE/REQ/SERVICE), register offset constants, and source index constants (TIMER0=0, TIMER1=1, EXT=2).
REQ-031 One sub-module irq_prio_enc: combinational lowest-index priority encoder, outputs valid flag and id.

Verification
REQ-032 Reset, MASK=0x3F, pulse src[1] at cycle 0 -> irq_req=1, irq_id=1 at cycle 2; ack -> irq_req=0, ISR reads 0x02, PEND reads 0x00.
REQ-033 src[2] and src[0] rise same cycle, MASK=0x3F -> irq_id=0; ack, eoi -> irq_req reasserts with irq_id=2 two cycles after eoi.
REQ-034 MASK=0x00, src[0] pulse -> PEND reads 0x01, irq_req stays 0; write MASK=0x01 -> irq_req=1 next cycle.
REQ-035 In REQ with irq_id=1, write PEND=0x02 before ack -> irq_req=0 next edge, state IDLE.
REQ-036 Edge mode: hold src[0] high 10 cycles, ack, eoi -> exactly one request; level mode same stimulus -> second request after eoi.
REQ-037 Assert reset during SERVICE with p=0x04 -> all registers 0, irq_req=0 for all cycles until new src event.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register offsets within the controller window, and source indices.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] OFF_MASK = 2'd0;
  localparam logic [1:0] OFF_PEND = 2'd1;
  localparam logic [1:0] OFF_ISR  = 2'd2;
  localparam logic [1:0] OFF_EOI  = 2'd3;

  localparam int TIMER0 = 0;
  localparam int TIMER1 = 1;
  localparam int EXT    = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int N   = 6,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  output logic           vld,
  output logic [IDW-1:0] id
);

  always_comb begin
    vld = |req;
    id  = '0;
    // scan downward so the last hit is the lowest index
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Single-level interrupt controller with MASK/PEND/ISR/EOI registers.
// Define IRQ_CTRL_EDGE_EN for rising-edge source detection (level otherwise).
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq_req,
  output logic [IDW-1:0]  irq_id,
  input  logic            irq_ack,
  input  logic            eoi
);

  state_t          state;
  logic [NSRC-1:0] pend, mask, isr;
  logic [NSRC-1:0] set_ev, pend_clr, ack_sel, elig;
  logic            elig_vld;
  logic [IDW-1:0]  elig_id;
  logic            wr_mask, wr_pend, eoi_hit;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:NSRC];

`ifdef IRQ_CTRL_EDGE_EN
  logic [NSRC-1:0] src_q;

  always_ff @(posedge clk) begin
    if (reset) src_q <= '0;
    else       src_q <= src;
  end

  assign set_ev = src & ~src_q;
`else
  assign set_ev = src;
`endif

  assign wr_mask  = we && (addr == OFF_MASK);
  assign wr_pend  = we && (addr == OFF_PEND);
  assign eoi_hit  = eoi || (we && (addr == OFF_EOI));
  assign ack_sel  = (state == REQ && irq_ack) ? (NSRC'(1) << irq_id) : '0;
  assign pend_clr = (wr_pend ? wdata[NSRC-1:0] : '0) | ack_sel;
  assign elig     = pend & mask & ~isr;

  irq_prio_enc #(.N(NSRC), .IDW(IDW)) u_enc (
    .req (elig),
    .vld (elig_vld),
    .id  (elig_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pend    <= '0;
      mask    <= '0;
      isr     <= '0;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      // a new set event in the same cycle beats any clear
      pend <= (pend & ~pend_clr) | set_ev;
      if (wr_mask) mask <= wdata[NSRC-1:0];
      case (state)
        IDLE: if (elig_vld) begin
          state   <= REQ;
          irq_req <= 1'b1;
          irq_id  <= elig_id;
        end
        REQ: if (irq_ack) begin
          state   <= SERVICE;
          irq_req <= 1'b0;
          isr     <= isr | ack_sel;
        end else if (!elig_vld) begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end else begin
          irq_id  <= elig_id;
        end
        SERVICE: if (eoi_hit) begin
          state <= IDLE;
          isr   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      OFF_MASK: rdata[NSRC-1:0] = mask;
      OFF_PEND: rdata[NSRC-1:0] = pend;
      OFF_ISR:  rdata[NSRC-1:0] = isr;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; expectations follow IRQ_CTRL_EDGE_EN if defined.
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int NSRC = 6;
  localparam int IDW  = 3;
`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src;
  logic [1:0]      addr;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq_req;
  logic [IDW-1:0]  irq_id;
  logic            irq_ack;
  logic            eoi;

  int n_chk  = 0;
  int n_fail = 0;

  irq_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack),
    .eoi     (eoi)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src = '0; addr = OFF_MASK; we = 1'b0; wdata = '0;
    irq_ack = 1'b0; eoi = 1'b0;
    step(2);
    reset = 1'b0;

    // reset state
    chk("rst_req", irq_req, 0);
    chk("rst_id", irq_id, 0);
    chk_reg("rst_mask", OFF_MASK, 0);
    chk_reg("rst_pend", OFF_PEND, 0);
    chk_reg("rst_isr", OFF_ISR, 0);

    // single Timer1 pulse: request two edges later, then ack
    wr(OFF_MASK, 32'h3F);
    src = 6'b000010; step(); src = '0; step();
    chk("t1_req", irq_req, 1);
    chk("t1_id", irq_id, TIMER1);
    pulse_ack();
    chk("t1_ack_req", irq_req, 0);
    chk_reg("t1_isr", OFF_ISR, 32'h02);
    chk_reg("t1_pend", OFF_PEND, 32'h00);
    wr(OFF_ISR, 32'h3F);
    chk_reg("isr_ro", OFF_ISR, 32'h02);
    pulse_eoi();
    chk_reg("t1_eoi_isr", OFF_ISR, 0);
    chk("t1_eoi_req", irq_req, 0);

    // simultaneous Timer0 + EXT: Timer0 first, EXT two cycles after eoi
    src = 6'b000101; step(); src = '0; step();
    chk("pri_req", irq_req, 1);
    chk("pri_id", irq_id, TIMER0);
    pulse_ack();
    chk("pri_ack_req", irq_req, 0);
    chk_reg("pri_isr", OFF_ISR, 32'h01);
    chk_reg("pri_pend", OFF_PEND, 32'h04);
    step(2);
    chk("nonest_req", irq_req, 0);
    pulse_eoi();
    chk("eoi_p1_req", irq_req, 0);
    step();
    chk("eoi_p2_req", irq_req, 1);
    chk("eoi_p2_id", irq_id, EXT);
    pulse_ack();
    // eoi pulse and EOI write in the same cycle count once
    eoi = 1'b1;
    wr(OFF_EOI, 32'h0);
    eoi = 1'b0;
    chk_reg("dbl_eoi_isr", OFF_ISR, 0);
    step();
    chk("dbl_eoi_req", irq_req, 0);
    pulse_ack();
    chk_reg("stray_ack_isr", OFF_ISR, 0);

    // masked source stays pending, unmask raises request
    wr(OFF_MASK, 32'h00);
    src = 6'b000001; step(); src = '0; step(2);
    chk("msk_req", irq_req, 0);
    chk_reg("msk_pend", OFF_PEND, 32'h01);
    wr(OFF_MASK, 32'h01);
    chk_reg("msk_rd", OFF_MASK, 32'h01);
    step();
    chk("unmsk_req", irq_req, 1);
    chk("unmsk_id", irq_id, TIMER0);
    // masking again withdraws the request without touching pending
    wr(OFF_MASK, 32'h00);
    step();
    chk("remsk_req", irq_req, 0);
    chk_reg("remsk_pend", OFF_PEND, 32'h01);
    wr(OFF_PEND, 32'h01);
    wr(OFF_MASK, 32'h3F);

    // PEND clear while requesting drops the request
    src = 6'b000010; step(); src = '0; step();
    chk("clr_pre_id", irq_id, TIMER1);
    wr(OFF_PEND, 32'h02);
    step();
    chk("clr_req", irq_req, 0);
    chk_reg("clr_pend", OFF_PEND, 0);
    step();
    chk("clr_idle_req", irq_req, 0);

    // higher-priority source preempts the id while in REQ
    src = 6'b000100; step(); src = '0; step();
    chk("pre_id_a", irq_id, EXT);
    src = 6'b000010; step(); src = '0; step();
    chk("pre_req", irq_req, 1);
    chk("pre_id_b", irq_id, TIMER1);
    wr(OFF_PEND, 32'h06);
    step();
    chk("pre_clr_req", irq_req, 0);

    // set event in the same cycle as a PEND clear wins
    src = 6'b000100;
    wr(OFF_PEND, 32'h04);
    src = '0;
    chk_reg("setwin_pend", OFF_PEND, 32'h04);
    step();
    chk("setwin_req", irq_req, 1);
    wr(OFF_PEND, 32'h04);
    step();
    chk("setwin_clr_req", irq_req, 0);

    // src held high across request, ack and eoi
    src = 6'b000001;
    step(2);
    chk("hold_req", irq_req, 1);
    chk("hold_id", irq_id, TIMER0);
    step(8);
    pulse_ack();
    src = '0;
    chk("hold_ack_req", irq_req, 0);
    chk_reg("hold_pend", OFF_PEND, EDGE ? 32'h00 : 32'h01);
    pulse_eoi();
    step();
    chk("hold_2nd_req", irq_req, EDGE ? 32'h0 : 32'h1);
    if (!EDGE) begin
      pulse_ack();
      pulse_eoi();
    end
    step();
    chk("hold_done_req", irq_req, 0);

    // reset during SERVICE with EXT pending dominates every input
    src = 6'b000001; step(); src = '0; step();
    pulse_ack();
    src = 6'b000100; step(); src = '0;
    chk_reg("svc_pend", OFF_PEND, 32'h04);
    chk("svc_req", irq_req, 0);
    reset = 1'b1; we = 1'b1; addr = OFF_MASK; wdata = 32'h3F;
    irq_ack = 1'b1; eoi = 1'b1;
    step();
    reset = 1'b0; we = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    chk_reg("rst2_mask", OFF_MASK, 0);
    chk_reg("rst2_pend", OFF_PEND, 0);
    chk_reg("rst2_isr", OFF_ISR, 0);
    chk("rst2_id", irq_id, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rst2_req", irq_req, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
